// File: rtl/heap_pkg.sv
// heap_pkg: state encoding and heap index helpers shared by heap_pq
package heap_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SIFT_UP = 2'd1, SIFT_DOWN = 2'd2} state_t;
    localparam int IDX_W = 16;
    function automatic logic [IDX_W-1:0] parent_idx(input logic [IDX_W-1:0] i);
        return (i - 1'b1) >> 1;
    endfunction
    function automatic logic [IDX_W-1:0] left_idx(input logic [IDX_W-1:0] i);
        return (i << 1) + 1'b1;
    endfunction
endpackage

// File: rtl/heap_key_cmp.sv
// heap_key_cmp: picks the better child and decides whether it must swap with the node
module heap_key_cmp #(
    parameter int KEY_WIDTH = 4,
    parameter bit MAX_FIRST = 1'b0
) (
    input  logic [KEY_WIDTH-1:0] node_key,
    input  logic [KEY_WIDTH-1:0] left_key,
    input  logic [KEY_WIDTH-1:0] right_key,
    input  logic                 left_ok,
    input  logic                 right_ok,
    output logic                 sel_right,
    output logic                 swap
);
    logic [KEY_WIDTH-1:0] child_key;
    function automatic logic better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
        return MAX_FIRST ? (a > b) : (a < b);
    endfunction
    assign sel_right = right_ok && (!left_ok || better(right_key, left_key));
    assign child_key = sel_right ? right_key : left_key;
    assign swap = (left_ok || right_ok) && better(child_key, node_key);
endmodule

// File: rtl/heap_pq.sv
// heap_pq: binary-heap priority queue with valid/ready on both sides and min/max ordering
module heap_pq
    import heap_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = 4,
    parameter int NLEVELS    = 3,
    parameter bit MAX_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NLEVELS-1:0]    count,
    output logic                  full,
    output logic                  empty
);
    localparam int CAP = 2**NLEVELS - 1;
    localparam int IW  = NLEVELS + 1;
    logic [DATA_WIDTH-1:0] heap [CAP];
    logic [DATA_WIDTH-1:0] hp [2**IW];
    state_t state, state_n;
    logic [NLEVELS-1:0] cur, cur_n, count_n, tgt, wr_idx;
    logic [IW-1:0] par, lc, rc;
    logic [DATA_WIDTH-1:0] wr_data;
    logic push, pop, wr_en, do_swap, sel_right, swap, up;
    // zero-padded view so out-of-range child/parent indices read harmlessly
    for (genvar g = 0; g < 2**IW; g++) begin : g_hp
        if (g < CAP) begin : g_r
            assign hp[g] = heap[g];
        end else begin : g_z
            assign hp[g] = '0;
        end
    end
    assign up = state == SIFT_UP;
    assign par = IW'(parent_idx(IDX_W'({1'b0, cur})));
    assign lc = IW'(left_idx(IDX_W'({1'b0, cur})));
    assign rc = lc + 1'b1;
    heap_key_cmp #(.KEY_WIDTH(KEY_WIDTH), .MAX_FIRST(MAX_FIRST)) u_cmp (
        .node_key (up ? hp[par][KEY_WIDTH-1:0] : hp[{1'b0, cur}][KEY_WIDTH-1:0]),
        .left_key (up ? hp[{1'b0, cur}][KEY_WIDTH-1:0] : hp[lc][KEY_WIDTH-1:0]),
        .right_key(hp[rc][KEY_WIDTH-1:0]),
        .left_ok  (up || (lc < {1'b0, count})),
        .right_ok (!up && (rc < {1'b0, count})),
        .sel_right(sel_right),
        .swap     (swap)
    );
    assign tgt = up ? par[NLEVELS-1:0] : (sel_right ? rc[NLEVELS-1:0] : lc[NLEVELS-1:0]);
    assign full = &count;
    assign empty = ~|count;
    assign in_ready = (state == IDLE) && !full;
    assign out_valid = (state == IDLE) && !empty;
    assign out_data = heap[0];
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    always_comb begin
        state_n = state;
        cur_n = cur;
        count_n = count;
        wr_en = 1'b0;
        wr_idx = count;
        wr_data = in_data;
        do_swap = 1'b0;
        if (flush) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: if (push || pop) begin
                    wr_en = 1'b1;
                    wr_idx = pop ? '0 : count;
                    wr_data = (pop && !push) ? hp[{1'b0, count - 1'b1}] : in_data;
                    count_n = (push && pop) ? count : (push ? count + 1'b1 : count - 1'b1);
                    cur_n = pop ? '0 : count;
                    state_n = pop ? ((count == NLEVELS'(1)) ? IDLE : SIFT_DOWN) : (empty ? IDLE : SIFT_UP);
                end
                SIFT_UP: if (cur != '0 && swap) begin
                    do_swap = 1'b1;
                    cur_n = tgt;
                end else state_n = IDLE;
                SIFT_DOWN: if (swap) begin
                    do_swap = 1'b1;
                    cur_n = tgt;
                end else state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cur <= '0;
            count <= '0;
            for (int i = 0; i < CAP; i++) heap[i] <= '0;
        end else begin
            state <= state_n;
            cur <= cur_n;
            count <= count_n;
            if (do_swap) begin
                heap[cur] <= hp[{1'b0, tgt}];
                heap[tgt] <= hp[{1'b0, cur}];
            end else if (wr_en) heap[wr_idx] <= wr_data;
        end
    end
endmodule
